// File: rtl/risc_pkg.sv
// Shared types for the VeriRisc core: opcodes, sequencer phases and opcode helpers.
package risc_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned PHASE_W  = 3;

  typedef enum logic [OPCODE_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes whose result is taken from the ALU into the accumulator.
  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational strobe decode from (phase, opcode, zero, halted).
module ctrl_decode
  import risc_pkg::*;
(
  input  phase_t  phase,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    halted,
  output logic    sel,
  output logic    rd,
  output logic    ld_ir,
  output logic    halt,
  output logic    inc_pc,
  output logic    ld_pc,
  output logic    ld_ac,
  output logic    wr,
  output logic    data_e
);

  logic aluop;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    aluop  = is_aluop(opcode);
    // A halted core masks everything except the halt indication.
    if (halted) begin
      halt = 1'b1;
    end else begin
      unique case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode != HLT);
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/risc_controller.sv
// VeriRisc instruction sequencer: 8-phase register, sticky halt and optional
// single-step gating of INST_ADDR (CTRL_SINGLE_STEP_EN).
module risc_controller
  import risc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                ld_ac,
  output logic                wr,
  output logic                data_e
);

  phase_t  phase_q, phase_d;
  logic    halted_q, halted_d;
  logic    advance;
  opcode_t op;

  assign op = opcode_t'(opcode);

`ifdef CTRL_SINGLE_STEP_EN
  assign advance = (phase_q != INST_ADDR) || step;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // HLT freezes the phase at OP_ADDR; only reset leaves the halted state.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if ((phase_q == OP_ADDR) && (op == HLT)) begin
        halted_d = 1'b1;
      end else if (advance) begin
        phase_d = phase_t'(PHASE_W'(phase_q + PHASE_W'(1)));
      end
    end
  end

  ctrl_decode u_decode (
    .phase  (phase_q),
    .opcode (op),
    .zero   (zero),
    .halted (halted_q),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .halt   (halt),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e)
  );

endmodule
